// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: stage-register state encoding and per-stage payload structs.
package cpu_types_pkg;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_t;

  // Example EX/MEM payload; $bits(exmem_t) sets DATA_W at the EX/MEM boundary.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic [1:0]  mem_size;
    logic [23:0] rsvd;
  } exmem_t;

  localparam int EXMEM_W = $bits(exmem_t);

  function automatic logic [1:0] occ_of(pipe_state_t s);
    case (s)
      PS_ONE:  occ_of = 2'd1;
      PS_TWO:  occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready flow control, flush and an
// optional 2-entry skid buffer that registers in_ready to cut the stall path.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int                 DATA_W     = 128,
  parameter bit                 SKID       = 1'b1,
  parameter logic [DATA_W-1:0]  RESET_DATA = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] main_q;
  logic              accept;
  logic              deq;

  assign accept   = in_valid & in_ready;
  assign deq      = out_valid & out_ready;
  assign out_data = main_q;

  generate
    if (SKID) begin : g_skid
      pipe_state_t       state_q, state_d;
      logic [DATA_W-1:0] skid_q;
      logic              rdy_q;
      logic              load_main, load_skid, main_from_skid;

      always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
          PS_EMPTY: if (accept) begin
            state_d   = PS_ONE;
            load_main = 1'b1;
          end
          PS_ONE: begin
            if (accept && deq) begin
              load_main = 1'b1;
            end else if (accept) begin
              state_d   = PS_TWO;
              load_skid = 1'b1;
            end else if (deq) begin
              state_d = PS_EMPTY;
            end
          end
          PS_TWO: if (deq) begin
            state_d        = PS_ONE;
            main_from_skid = 1'b1;
          end
          default: state_d = PS_EMPTY;
        endcase
        // Flush squashes entries but leaves data regs untouched; out_valid=0 masks them.
        if (flush) begin
          state_d        = PS_EMPTY;
          load_main      = 1'b0;
          load_skid      = 1'b0;
          main_from_skid = 1'b0;
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          state_q <= PS_EMPTY;
          rdy_q   <= 1'b1;
          main_q  <= RESET_DATA;
          skid_q  <= RESET_DATA;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != PS_TWO);
          if (load_main)           main_q <= in_data;
          else if (main_from_skid) main_q <= skid_q;
          if (load_skid)           skid_q <= in_data;
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state_q != PS_EMPTY);
      assign occupancy = occ_of(state_q);
    end else begin : g_single
      logic vld_q;

      always_ff @(posedge CLK) begin
        if (RST) begin
          vld_q  <= 1'b0;
          main_q <= RESET_DATA;
        end else if (flush) begin
          vld_q  <= 1'b0;
        end else begin
          vld_q <= accept | (vld_q & ~out_ready);
          if (accept) main_q <= in_data;
        end
      end

      assign in_ready  = out_ready | ~vld_q;
      assign out_valid = vld_q;
      assign occupancy = {1'b0, vld_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances share stimulus; each is
// scored against its own queue model, plus a vector table and directed corner cases.
module tb_pipe_stage_reg;

  localparam int          DW = 16;
  localparam logic [15:0] RD = 16'hA5A5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 CLK = ~CLK;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b0), .RESET_DATA(RD)) u_s0 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0));

  pipe_stage_reg #(.DATA_W(DW), .SKID(1'b1), .RESET_DATA(RD)) u_s1 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1));

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          fl;
    logic          e_vld;
    logic [DW-1:0] e_data;
    logic [1:0]    e_occ;
    logic          e_rdy;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model view: SKID=0 holds at most one entry and is ready when empty or draining;
  // SKID=1 holds up to two and is ready whenever it is not full.
  task automatic check_all();
    chk("s0_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
    chk("s0_occupancy", 32'(occ0), 32'(q0.size()));
    chk("s0_in_ready", 32'(in_ready0), 32'(out_ready || q0.size() == 0));
    if (q0.size() > 0) chk("s0_out_data", 32'(out_data0), 32'(q0[0]));
    chk("s1_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
    chk("s1_occupancy", 32'(occ1), 32'(q1.size()));
    chk("s1_in_ready", 32'(in_ready1), 32'(q1.size() < 2));
    if (q1.size() > 0) chk("s1_out_data", 32'(out_data1), 32'(q1[0]));
  endtask

  task automatic model_edge();
    bit acc0, acc1, deq0, deq1;
    if (RST || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      acc0 = in_valid && (out_ready || q0.size() == 0);
      deq0 = out_ready && q0.size() > 0;
      acc1 = in_valid && q1.size() < 2;
      deq1 = out_ready && q1.size() > 0;
      if (deq0) void'(q0.pop_front());
      if (acc0) q0.push_back(in_data);
      if (deq1) void'(q1.pop_front());
      if (acc1) q1.push_back(in_data);
    end
  endtask

  task automatic cyc_begin(input logic iv, input logic [DW-1:0] d, input logic ordy,
                           input logic fl, input logic rst);
    @(negedge CLK);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    RST       = rst;
    #1;
    if (chk_en) check_all();
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                      input logic fl, input logic rst);
    cyc_begin(iv, d, ordy, fl, rst);
    model_edge();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_s0_data"}, 32'(out_data0), 32'(RD));
    chk({tag, "_s1_data"}, 32'(out_data1), 32'(RD));
    chk({tag, "_s0_valid"}, 32'(out_valid0), 32'd0);
    chk({tag, "_s1_valid"}, 32'(out_valid1), 32'd0);
    chk({tag, "_s1_occ"}, 32'(occ1), 32'd0);
    chk({tag, "_s0_rdy"}, 32'(in_ready0), 32'd1);
    chk({tag, "_s1_rdy"}, 32'(in_ready1), 32'd1);
  endtask

  vec_t tbl[12];

  initial begin
    // SKID=1 expectations for backpressure, drain and flush-with-input, from empty.
    tbl[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    tbl[1]  = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd1, 1'b1};
    tbl[2]  = '{1'b1, 16'h00C3, 1'b0, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0};
    tbl[4]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b1, 16'h00B2, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h00C3, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 16'h00D4, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    tbl[7]  = '{1'b1, 16'h00E5, 1'b0, 1'b0, 1'b1, 16'h00D4, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 16'h00F6, 1'b0, 1'b1, 1'b1, 16'h00D4, 2'd2, 1'b0};
    tbl[9]  = '{1'b1, 16'h0077, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 16'h0088, 1'b0, 1'b1, 1'b1, 16'h0077, 2'd1, 1'b1};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1};

    // Reset with in_valid high for two cycles.
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
    cyc_begin(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_reset_state("reset");
    model_edge();

    for (int i = 0; i < 12; i++) begin
      cyc_begin(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, 1'b0);
      chk($sformatf("tbl%0d_vld", i), 32'(out_valid1), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_occ", i), 32'(occ1), 32'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_rdy", i), 32'(in_ready1), 32'(tbl[i].e_rdy));
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_data", i), 32'(out_data1), 32'(tbl[i].e_data));
      model_edge();
    end

    // Streaming 1..8 with the sink always ready.
    for (int k = 1; k <= 8; k++) begin
      cyc_begin(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
      chk("stream_s0_rdy", 32'(in_ready0), 32'd1);
      chk("stream_s1_rdy", 32'(in_ready1), 32'd1);
      if (k > 1) chk("stream_s1_data", 32'(out_data1), 32'(k - 1));
      model_edge();
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // SKID=0 in_ready follows out_ready within a cycle; SKID=1 in_ready does not.
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    cyc_begin(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rdy_path_lo", 32'(in_ready0), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("rdy_path_hi", 32'(in_ready0), 32'd1);
    chk("rdy_path_s1", 32'(in_ready1), 32'(q1.size() < 2));
    chk("rdy_path_data", 32'(out_data0), 32'h5A5A);
    out_ready = 1'b0;
    #1;
    chk("rdy_path_lo2", 32'(in_ready0), 32'd0);
    chk("rdy_path_hold", 32'(out_data0), 32'h5A5A);
    model_edge();
    step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomised run, 1% flush.
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 99) == 0), 1'b0);
    end

    // Reset mid-stall wins over flush and reloads RESET_DATA.
    step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h4444, 1'b0, 1'b1, 1'b1);
    cyc_begin(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_reset_state("midrst");
    model_edge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
